adc_pretrig_capture: RTL
========================

Name: adc_pretrig_capture

Overview:
- Parametrised successor to the fixed 14-bit, 100-tap ADC delay line.
- Continuously records ADC samples into a circular buffer of DEPTH entries.
- On trigger, freezes a window of PRE pre-trigger samples and DEPTH-PRE post-trigger samples.
- Streams the window oldest-first over a valid/ready interface to the UART transmit path.

Parameters:
WIDTH, 14, ADC sample width in bits
DEPTH, 100, capture window length in samples (any integer >= 2; need not be a power of two)
PRE, 50, pre-trigger samples in window; legal range 0..DEPTH-1

Ports:
clk  in  1  sample clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
adc_in  in  WIDTH  ADC sample, one per clk
arm  in  1  start capture; honoured only in IDLE
trig  in  1  trigger, level-sampled each clk; honoured only in ARMED
abort  in  1  synchronous return to IDLE from any state
out_data  out  WIDTH  readout sample
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts when high with out_valid
out_last  out  1  marks final sample of window (with out_valid)
state  out  3  IDLE=0, FILL=1, ARMED=2, POST=3, READ=4

Behaviour:
- Reset (async, any time, including mid-readout): state=IDLE; wr_ptr, rd_ptr, fill_cnt, post_cnt = 0; out_valid=0, out_last=0, out_data=0. Buffer contents need not be cleared.
- Write rule: at every edge where the pre-edge state is FILL, ARMED or POST:
  - mem[wr_ptr] <= adc_in.
  - wr_ptr advances by 1 and wraps DEPTH-1 -> 0.
  - No writes in IDLE or READ; wr_ptr holds.
- IDLE:
  - arm=1 -> FILL with fill_cnt=0.
  - If PRE=0, arm=1 goes straight to ARMED.
- FILL:
  - Each write increments fill_cnt.
  - The write that makes fill_cnt==PRE moves to ARMED.
  - trig is ignored, which guarantees PRE genuine pre-trigger samples.
- ARMED:
  - Writes continue and old samples are overwritten.
  - On an edge with trig=1, the sample written at that edge is the trigger sample; post_cnt=1.
  - If DEPTH-PRE==1 go to READ; otherwise go to POST.
- POST:
  - Each write increments post_cnt.
  - The write making post_cnt==DEPTH-PRE moves to READ.
  - trig is ignored.
- READ entry: rd_ptr <= wr_ptr (the oldest sample); rd_cnt=0.
  - Window order: read index PRE is the trigger sample.
- READ:
  - out_valid=1 from the first cycle in READ.
  - out_data = mem[rd_ptr].
  - out_last = (rd_cnt==DEPTH-1).
  - On out_valid && out_ready: rd_ptr advances with wrap and rd_cnt++.
  - The transfer with out_last moves to IDLE; out_valid=0 on the next cycle.
- Handshake: while out_valid && !out_ready, out_data and out_last are held stable. out_ready has no effect outside READ.
- arm in any non-IDLE state is ignored. arm and trig are evaluated only in their own states, so simultaneous arm+trig in IDLE only arms.
- abort=1 -> IDLE at the next edge from any state:
  - Overrides all other transitions.
  - Clears out_valid and out_last.
  - Suppresses the write at that edge.
- Throughput: one sample per clk when out_ready is held high. Readout of the full window takes exactly DEPTH cycles.
- All counters are sized $clog2(DEPTH+1). Arithmetic is unsigned with no saturation.

Test Plan:
- DEPTH=8, PRE=3, adc_in=free-running counter; arm, then trig on the cycle adc_in=20 -> out_data 17..24 on 8 consecutive cycles (out_ready=1); out_last only with 24; state returns to 0.
- Same setup, trig asserted during FILL (first 3 writes) then held low, then pulsed at adc_in=40 -> early trig ignored; window 37..44.
- Back-pressure: out_ready toggled 1,0,0,1,... during READ -> out_data/out_last stable while stalled; every value 17..24 delivered exactly once, in order.
- PRE=0, DEPTH=4: arm then trig at adc_in=10 -> window 10,11,12,13; trigger sample first. PRE=DEPTH-1=3: window 7,8,9,10 with trigger last, and no POST state.
- abort in POST, and separately mid-READ after 3 transfers -> state=0 next cycle, out_valid=0; a fresh arm/trig yields a complete correct window.
- Async rst pulsed mid-READ, between clock edges -> out_valid, out_last, out_data and state go to 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/adc_pretrig_capture_if.sv
// Readout stream from the pre-trigger capture buffer toward the UART transmit path.
interface adc_pretrig_capture_if #(
   parameter int unsigned WIDTH = 14
);
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/adc_pretrig_capture.sv
// Circular ADC capture buffer: records continuously, freezes PRE pre-trigger and
// DEPTH-PRE post-trigger samples on trigger, then streams the window oldest-first.
module adc_pretrig_capture #(
   parameter int unsigned WIDTH = 14,
   parameter int unsigned DEPTH = 100,
   parameter int unsigned PRE   = 50
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       adc_in,
   input  logic                   arm,
   input  logic                   trig,
   input  logic                   abort,
   adc_pretrig_capture_if.master  rd,
   output logic [2:0]             state
);
   localparam int unsigned CW     = $clog2(DEPTH + 1);
   localparam int unsigned PW     = $clog2(DEPTH);
   localparam int unsigned POST_N = DEPTH - PRE;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_ARMED = 3'd2,
      S_POST  = 3'd3,
      S_READ  = 3'd4
   } state_t;

   state_t           st;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_nxt;
   logic [PW-1:0]    rd_nxt;
   logic [CW-1:0]    fill_cnt;
   logic [CW-1:0]    post_cnt;
   logic [CW-1:0]    rd_cnt;
   logic             wr_en;
   logic [WIDTH-1:0] mem [DEPTH];

   assign state = st;

   // Recording runs in FILL/ARMED/POST; abort suppresses the write at its edge.
   always_comb begin
      wr_en  = 1'b0;
      wr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      rd_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (!abort && (st == S_FILL || st == S_ARMED || st == S_POST)) begin
         wr_en = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= adc_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st           <= S_IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fill_cnt     <= '0;
         post_cnt     <= '0;
         rd_cnt       <= '0;
         rd.out_valid <= 1'b0;
         rd.out_last  <= 1'b0;
         rd.out_data  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_nxt;
         end
         if (abort) begin
            st           <= S_IDLE;
            rd.out_valid <= 1'b0;
            rd.out_last  <= 1'b0;
         end else begin
            case (st)
               S_IDLE: begin
                  if (arm) begin
                     fill_cnt <= '0;
                     st       <= (PRE == 0) ? S_ARMED : S_FILL;
                  end
               end
               S_FILL: begin
                  fill_cnt <= fill_cnt + CW'(1);
                  if (fill_cnt + CW'(1) == CW'(PRE)) begin
                     st <= S_ARMED;
                  end
               end
               S_ARMED: begin
                  if (trig) begin
                     post_cnt <= CW'(1);
                     if (POST_N == 1) begin
                        // The slot after the final write holds the oldest sample.
                        st           <= S_READ;
                        rd_ptr       <= wr_nxt;
                        rd_cnt       <= '0;
                        rd.out_valid <= 1'b1;
                        rd.out_last  <= 1'b0;
                        rd.out_data  <= mem[wr_nxt];
                     end else begin
                        st <= S_POST;
                     end
                  end
               end
               S_POST: begin
                  post_cnt <= post_cnt + CW'(1);
                  if (post_cnt + CW'(1) == CW'(POST_N)) begin
                     st           <= S_READ;
                     rd_ptr       <= wr_nxt;
                     rd_cnt       <= '0;
                     rd.out_valid <= 1'b1;
                     rd.out_last  <= 1'b0;
                     rd.out_data  <= mem[wr_nxt];
                  end
               end
               S_READ: begin
                  if (rd.out_valid && rd.out_ready) begin
                     rd_ptr      <= rd_nxt;
                     rd_cnt      <= rd_cnt + CW'(1);
                     rd.out_data <= mem[rd_nxt];
                     rd.out_last <= (rd_cnt + CW'(1) == CW'(DEPTH - 1));
                     if (rd.out_last) begin
                        st           <= S_IDLE;
                        rd.out_valid <= 1'b0;
                        rd.out_last  <= 1'b0;
                     end
                  end
               end
               default: st <= S_IDLE;
            endcase
         end
      end
   end
endmodule
